// File: rtl/ctrl_br_pkg.sv
// Shared definitions for the register-file controller: FSM states and
// R-type opcode/funct encodings.
package ctrl_br_pkg;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    LECTURA   = 2'd1,
    EJECUCION = 2'd2,
    ESCRITURA = 2'd3
  } estado_t;

  localparam logic [5:0] OP_R  = 6'b000000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_XOR = 6'b100110;

endpackage

// File: rtl/ctrl_br_alu.sv
// Combinational R-type ALU: result plus a flag saying whether funct is supported.
module alu_r
  import ctrl_br_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [5:0]       funct,
  output logic [ANCHO-1:0] res,
  output logic             valido
);

  always_comb begin
    res    = '0;
    valido = 1'b1;
    case (funct)
      F_ADD: res = a + b;
      F_SUB: res = a - b;
      F_AND: res = a & b;
      F_OR:  res = a | b;
      F_XOR: res = a ^ b;
      F_SLT: res = {{(ANCHO-1){1'b0}}, ($signed(a) < $signed(b))};
      default: valido = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_br.sv
// Register-file controller: fetches two operands, executes an R-type op and
// writes the result back, one instruction every four cycles.
module ctrl_br
  import ctrl_br_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             listo,
  output logic [4:0]       DL1,
  output logic [4:0]       DL2,
  input  logic [ANCHO-1:0] op1,
  input  logic [ANCHO-1:0] op2,
  output logic [4:0]       DE,
  output logic [ANCHO-1:0] DATO,
  output logic             WE,
  output logic             hecho,
  output logic             error
);

  estado_t          estado, estado_sig;
  logic [5:0]       opcode_q;
  logic [5:0]       funct_q;
  logic [4:0]       rd_q;
  logic [ANCHO-1:0] a_q, b_q;
  logic [ANCHO-1:0] alu_res;
  logic             alu_valido;
  logic             soportada;
  logic             unused_shamt;

  assign unused_shamt = ^instr[10:6];
  assign listo        = (estado == INACTIVO);
  assign soportada    = (opcode_q == OP_R) && alu_valido;

  alu_r #(.ANCHO(ANCHO)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .funct  (funct_q),
    .res    (alu_res),
    .valido (alu_valido)
  );

  always_comb begin
    estado_sig = estado;
    case (estado)
      INACTIVO:  if (instr_valid) estado_sig = LECTURA;
      LECTURA:   estado_sig = EJECUCION;
      EJECUCION: estado_sig = ESCRITURA;
      ESCRITURA: estado_sig = INACTIVO;
      default:   estado_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= INACTIVO;
    else        estado <= estado_sig;
  end

  // Read addresses come straight from the offered instruction so they are
  // already registered and stable during the whole LECTURA cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      funct_q  <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      DL1      <= '0;
      DL2      <= '0;
      DE       <= '0;
      DATO     <= '0;
      WE       <= 1'b0;
      hecho    <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (estado)
        INACTIVO: begin
          if (instr_valid) begin
            opcode_q <= instr[31:26];
            DL1      <= instr[25:21];
            DL2      <= instr[20:16];
            rd_q     <= instr[15:11];
            funct_q  <= instr[5:0];
          end
        end
        LECTURA: begin
          a_q <= op1;
          b_q <= op2;
        end
        EJECUCION: begin
          DE    <= rd_q;
          DATO  <= alu_res;
          WE    <= soportada && (rd_q != 5'd0);
          hecho <= 1'b1;
          error <= !soportada;
        end
        ESCRITURA: begin
          WE    <= 1'b0;
          hecho <= 1'b0;
          error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_br.sv
// Directed bench for ctrl_br with a behavioural register file and a scoreboard
// of expected retirements.
module tb_ctrl_br;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        listo;
  logic [4:0]  DL1, DL2, DE;
  logic [31:0] op1, op2, DATO;
  logic        WE, hecho, error;

  logic [31:0] br [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  int          nwrites = 0;

  int nasrt = 0;
  int nfail = 0;

  typedef struct {
    logic [4:0]  de;
    logic [31:0] dato;
    logic        we;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ctrl_br #(.ANCHO(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .listo       (listo),
    .DL1         (DL1),
    .DL2         (DL2),
    .op1         (op1),
    .op2         (op2),
    .DE          (DE),
    .DATO        (DATO),
    .WE          (WE),
    .hecho       (hecho),
    .error       (error)
  );

  assign op1 = br[DL1];
  assign op2 = br[DL2];

  always @(posedge clk) begin
    if (pl_en) br[pl_addr] <= pl_data;
    else if (WE) begin
      br[DE]  <= DATO;
      nwrites <= nwrites + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nasrt++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_hecho(input string tag, output int ciclos);
    ciclos = 0;
    do begin
      @(negedge clk);
      ciclos++;
    end while (hecho !== 1'b1 && ciclos < 12);
    if (hecho !== 1'b1) chk({tag, "_timeout"}, {63'd0, hecho}, 64'd1);
  endtask

  task automatic retire(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_hecho"}, {63'd0, hecho}, 64'd1);
    chk({tag, "_we"},    {63'd0, WE},    {63'd0, e.we});
    chk({tag, "_error"}, {63'd0, error}, {63'd0, e.err});
    chk({tag, "_de"},    {59'd0, DE},    {59'd0, e.de});
    if (e.we) chk({tag, "_dato"}, {32'd0, DATO}, {32'd0, e.dato});
  endtask

  task automatic run(input string tag, input logic [31:0] iw, input logic exp_we,
                     input logic exp_err, input logic [31:0] exp_dato);
    exp_t e;
    int   c, w0;
    logic [31:0] old;
    e.de = iw[15:11]; e.dato = exp_dato; e.we = exp_we; e.err = exp_err;
    old = br[iw[15:11]];
    sb.push_back(e);
    w0 = nwrites;
    @(negedge clk);
    chk({tag, "_listo_idle"}, {63'd0, listo}, 64'd1);
    instr = iw; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_listo_busy"}, {63'd0, listo}, 64'd0);
    chk({tag, "_dl1"}, {59'd0, DL1}, {59'd0, iw[25:21]});
    chk({tag, "_dl2"}, {59'd0, DL2}, {59'd0, iw[20:16]});
    wait_hecho(tag, c);
    chk({tag, "_latency"}, 64'(c), 64'd2);
    retire(tag);
    @(negedge clk);
    chk({tag, "_listo_after"}, {63'd0, listo}, 64'd1);
    chk({tag, "_we_one_cycle"}, {63'd0, WE}, 64'd0);
    chk({tag, "_hecho_pulse"}, {63'd0, hecho}, 64'd0);
    chk({tag, "_nwrites"}, 64'(nwrites - w0), {63'd0, exp_we});
    chk({tag, "_br_rd"}, {32'd0, br[iw[15:11]]}, {32'd0, exp_we ? exp_dato : old});
  endtask

  initial begin
    int c, w0;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    #3;
    chk("rst_listo", {63'd0, listo}, 64'd1);
    chk("rst_we",    {63'd0, WE},    64'd0);
    chk("rst_hecho", {63'd0, hecho}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_dl1",   {59'd0, DL1},   64'd0);
    chk("rst_dl2",   {59'd0, DL2},   64'd0);
    chk("rst_de",    {59'd0, DE},    64'd0);
    chk("rst_dato",  {32'd0, DATO},  64'd0);
    for (int i = 0; i < 32; i++) preload(5'(i), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic add
    preload(5'd1, 32'd5); preload(5'd2, 32'd3);
    run("add", 32'h00221820, 1'b1, 1'b0, 32'd8);

    preload(5'd1, 32'd1); preload(5'd2, 32'd2);
    run("sub", mk(6'h00, 5'd1, 5'd2, 5'd4, 6'b100010), 1'b1, 1'b0, 32'hFFFFFFFF);
    run("slt", mk(6'h00, 5'd1, 5'd2, 5'd5, 6'b101010), 1'b1, 1'b0, 32'd1);
    preload(5'd6, 32'hFFFFFFFF);
    run("slt_neg_lt", mk(6'h00, 5'd6, 5'd1, 5'd7, 6'b101010), 1'b1, 1'b0, 32'd1);
    run("slt_pos_ge", mk(6'h00, 5'd1, 5'd6, 5'd7, 6'b101010), 1'b1, 1'b0, 32'd0);

    preload(5'd8, 32'hF0F01234); preload(5'd9, 32'h0FF0FF00);
    run("and", mk(6'h00, 5'd8, 5'd9, 5'd11, 6'b100100), 1'b1, 1'b0, 32'h00F01200);
    run("or",  mk(6'h00, 5'd8, 5'd9, 5'd12, 6'b100101), 1'b1, 1'b0, 32'hFFF0FF34);
    run("xor", mk(6'h00, 5'd8, 5'd9, 5'd13, 6'b100110), 1'b1, 1'b0, 32'hFF00ED34);

    preload(5'd1, 32'h7FFFFFFF); preload(5'd2, 32'd1);
    run("add_wrap", mk(6'h00, 5'd1, 5'd2, 5'd14, 6'b100000), 1'b1, 1'b0, 32'h80000000);

    preload(5'd15, 32'hCAFE0015);
    run("bad_opcode", mk(6'h23, 5'd1, 5'd2, 5'd15, 6'b100000), 1'b0, 1'b1, 32'd0);
    run("bad_funct",  mk(6'h00, 5'd1, 5'd2, 5'd15, 6'b000000), 1'b0, 1'b1, 32'd0);
    run("rd_zero",    mk(6'h00, 5'd1, 5'd2, 5'd0,  6'b100000), 1'b0, 1'b0, 32'd0);
    chk("r0_stays_zero", {32'd0, br[0]}, 64'd0);

    // instr_valid held high across a busy period: B waits for listo
    begin
      exp_t ea, eb;
      ea.de = 5'd16; ea.dato = 32'h80000000; ea.we = 1'b1; ea.err = 1'b0;
      eb.de = 5'd17; eb.dato = 32'h7FFFFFFE; eb.we = 1'b1; eb.err = 1'b0;
      sb.push_back(ea); sb.push_back(eb);
      w0 = nwrites;
      @(negedge clk);
      instr = mk(6'h00, 5'd1, 5'd2, 5'd16, 6'b100000); instr_valid = 1'b1;
      @(negedge clk);
      instr = mk(6'h00, 5'd1, 5'd2, 5'd17, 6'b100010);
      chk("held_a_dl1", {59'd0, DL1}, 64'd1);
      wait_hecho("held_a", c);
      retire("held_a");
      @(negedge clk);
      chk("held_listo", {63'd0, listo}, 64'd1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk("held_b_accepted", {63'd0, listo}, 64'd0);
      chk("held_b_de_prev",  {59'd0, DE},    64'd16);
      wait_hecho("held_b", c);
      chk("held_b_latency", 64'(c), 64'd2);
      retire("held_b");
      @(negedge clk);
      chk("held_two_writes", 64'(nwrites - w0), 64'd2);
      chk("held_br16", {32'd0, br[16]}, 64'h80000000);
      chk("held_br17", {32'd0, br[17]}, 64'h7FFFFFFE);
    end

    // reset while WE is high
    preload(5'd10, 32'h00001234);
    @(negedge clk);
    instr = mk(6'h00, 5'd1, 5'd2, 5'd10, 6'b100000); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    wait_hecho("rst_mid", c);
    chk("rst_mid_we_pre", {63'd0, WE}, 64'd1);
    w0 = nwrites;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we",    {63'd0, WE},    64'd0);
    chk("rst_mid_hecho", {63'd0, hecho}, 64'd0);
    chk("rst_mid_listo", {63'd0, listo}, 64'd1);
    chk("rst_mid_dato",  {32'd0, DATO},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_listo_after", {63'd0, listo}, 64'd1);
    chk("rst_mid_no_write", 64'(nwrites - w0), 64'd0);
    chk("rst_mid_br10", {32'd0, br[10]}, 64'h00001234);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
